// File: rtl/timer_device.sv
// timer_device
//   Memory-mapped timer responder for one timer window. Holds the CTRL,
//   PRESET and COUNT registers, runs a down-counter FSM and raises an
//   interrupt request toward CP0.
//
// Ports
//   clk        in   1   system clock, all state updates on the rising edge
//   reset_n    in   1   asynchronous, active-low reset
//   addr       in   2   word select (bus address [3:2]):
//                       0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped
//   we         in   1   write strobe, one cycle per word write
//   wd         in  32   write data
//   rd         out 32   read data, combinational from addr
//   irq        out  1   interrupt request = irq_flag & CTRL.IM
//   state_dbg  out  2   current FSM state (IDLE=0, LOAD=1, CNT=2, INT=3)
//
// Bus protocol: there is no handshake. A write commits at every rising edge
// where we=1 for the word selected by addr; a read is a pure combinational
// decode of addr and is valid in the same cycle.
//
// CTRL layout: bit0 EN, bits2:1 MODE (1 = auto-reload, anything else =
// one-shot), bit3 IM. Upper bits read as zero.

module timer_device (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state;
    state_t      state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_next;
    logic        irq_flag;

    logic        fsm_clr_en;
    logic        fsm_set_irq;
    logic        fsm_clr_irq;

    logic        wr_ctrl;
    logic        wr_preset;

    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_preset = we && (addr == A_PRESET);

    // Next-state logic works only from registered CTRL, so a bus write is
    // seen by the FSM one cycle after it commits.
    always_comb begin
        state_next  = state;
        count_next  = count;
        fsm_clr_en  = 1'b0;
        fsm_set_irq = 1'b0;
        fsm_clr_irq = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl[0]) state_next = S_LOAD;
            end
            S_LOAD: begin
                count_next = preset;
                state_next = S_CNT;
            end
            S_CNT: begin
                if (!ctrl[0]) begin
                    state_next = S_IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // COUNT of 0 or 1 both expire here, so PRESET=0 acts as 1.
                    count_next  = 32'd0;
                    fsm_set_irq = 1'b1;
                    state_next  = S_INT;
                end
            end
            S_INT: begin
                if (ctrl[2:1] == 2'd1) begin
                    fsm_clr_irq = 1'b1;
                    state_next  = S_LOAD;
                end else begin
                    fsm_clr_en = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;

            // A bus write to CTRL overrides the FSM's EN clear.
            if (wr_ctrl) begin
                ctrl <= wd[3:0];
            end else if (fsm_clr_en) begin
                ctrl[0] <= 1'b0;
            end

            if (wr_preset) preset <= wd;

            // Setting wins over any clear so an expiry is never lost.
            if (fsm_set_irq) begin
                irq_flag <= 1'b1;
            end else if (wr_ctrl || wr_preset || fsm_clr_irq) begin
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rd = 32'd0;
        case (addr)
            A_CTRL:   rd = {28'd0, ctrl};
            A_PRESET: rd = preset;
            A_COUNT:  rd = count;
            default:  rd = 32'd0;
        endcase
    end

    assign irq       = irq_flag & ctrl[3];
    assign state_dbg = state;

endmodule
